instr_streamer: RTL
===================

Name: instr_streamer

Overview:
- Program-loader block that drives the processor's instruction-load port: `valid` connects to the CPU's `li` input and `data` connects to the CPU's `instruction[15:0]` input.
- A host or testbench fills an internal program buffer word by word, then pulses `start`.
- The block then streams the buffered words to the CPU on consecutive cycles, holding `valid` high for the whole burst.
- It replaces the free-running assembler source with a controllable, replayable, stallable producer.

Parameters:
- WIDTH, 16, instruction word width; must match the CPU instruction port.
- DEPTH, 512, program buffer entries; matches the 9-bit instruction memory address space.
- AW, 9, buffer address width; must satisfy 2**AW >= DEPTH.

Ports:
- clk  input  1  rising-edge clock shared with the CPU.
- rst  input  1  synchronous active-high reset.
- wr_en  input  1  host write strobe; loads wr_data into the buffer.
- wr_data  input  WIDTH  instruction word to append.
- clear  input  1  empties the buffer and aborts any stream.
- start  input  1  one-cycle pulse that begins streaming.
- stall  input  1  pauses streaming while high.
- valid  output  1  instruction-load strobe to CPU `li`.
- data  output  WIDTH  instruction word to CPU `instruction`.
- count  output  AW+1  number of words currently buffered.
- full  output  1  high when count == DEPTH.
- busy  output  1  high while in the STREAM state.
- done  output  1  one-cycle pulse after the last word is streamed.
- wr_drop  output  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (rst sampled high at a rising edge):
  - state=IDLE; valid=0, data=0, count=0, busy=0, done=0, wr_drop=0; read and write pointers=0.
  - Buffer RAM contents are not reset.
  - Reset mid-stream forces valid=0 from the next cycle; no done pulse is produced.
- All outputs are registered. `full` is decoded from `count`.
- States:
  - IDLE: accepts writes and start.
  - STREAM: emits words.
  - No other states; done is generated on the STREAM->IDLE exit.
- Writes:
  - In IDLE, wr_en with count<DEPTH stores wr_data at wr_ptr; wr_ptr and count increment.
  - wr_en while full, or while in STREAM, is ignored and pulses wr_drop on the next cycle.
- Start:
  - start in IDLE with count>0: move to STREAM, rd_ptr=0.
  - start in IDLE with count=0: stay in IDLE and pulse done on the next cycle; valid stays 0.
  - start while in STREAM is ignored.
- Streaming latency:
  - If start is sampled at edge k, word0 appears with valid=1 after edge k+1.
  - Each following edge with stall=0 presents the next word.
  - N words therefore occupy N consecutive valid cycles when there is no stall.
- Stall:
  - Sampled each edge while in STREAM.
  - stall=1 drives valid=0 and data=0 on the next cycle and holds rd_ptr.
  - Streaming resumes with the same pending word when stall returns to 0.
- End of stream:
  - After the cycle presenting word N-1, the next cycle has valid=0, data=0, done=1, busy=0, and state=IDLE.
  - rd_ptr returns to 0. Buffer contents and count are retained, so a later start replays the same program.
- Clear:
  - Sets count=0 and both pointers to 0.
  - If clear arrives in STREAM, the stream aborts: valid=0 next cycle, no done pulse, return to IDLE.
- Simultaneous events:
  - clear beats start, wr_en, and stall.
  - wr_en together with start in IDLE: the write is accepted and the new word is included in the stream.
- When valid=0, data is always 0.

Test Plan:
- Reset, write 3 words (0x1001, 0x2002, 0x3003), pulse start -> count=3; valid high for exactly 3 consecutive cycles beginning one cycle after start, with data 0x1001, 0x2002, 0x3003 in order; done pulses on the following cycle with valid=0.
- Same program, stall high for 2 cycles after the first word -> valid low for 2 cycles, then 0x2002 and 0x3003 follow; 5 cycles total from first to last valid.
- After the first stream completes, pulse start again with no writes -> identical 3-word replay; count remains 3.
- Fill DEPTH words and issue one extra write of 0xFFFF -> full=1, wr_drop pulses once, count=DEPTH, and 0xFFFF never appears on data.
- Start with an empty buffer -> done pulses next cycle, valid never asserts. Separately, clear at the 2nd word of a 3-word stream -> valid=0 next cycle, no done pulse, count=0.
- Apply rst mid-stream -> valid=0 and count=0 the next cycle; a subsequent write of 0xABCD followed by start streams only 0xABCD.

Source files
------------

// File: rtl/instr_streamer_if.sv
// Host-side load/control bus and CPU-side instruction stream of the program loader.
interface instr_streamer_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 9
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             clear;
    logic             start;
    logic             stall;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [AW:0]      count;
    logic             full;
    logic             busy;
    logic             done;
    logic             wr_drop;

    modport slave (
        input  wr_en, wr_data, clear, start, stall,
        output valid, data, count, full, busy, done, wr_drop
    );

    modport master (
        output wr_en, wr_data, clear, start, stall,
        input  valid, data, count, full, busy, done, wr_drop
    );
endinterface

// File: rtl/instr_streamer.sv
// Buffers a program written by the host, then replays it to the CPU's li/instruction
// port as a stallable burst; all outputs registered, data forced to zero when not valid.
module instr_streamer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input logic            clk,
    input logic            rst,
    instr_streamer_if.slave bus
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, wr_ptr_n;
    logic [AW:0]      rd_ptr, rd_ptr_n;
    logic [AW:0]      count, count_n;
    logic             valid_q, valid_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             drop_q, drop_n;
    logic             mem_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state   <= state_n;
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            count   <= count_n;
            valid_q <= valid_n;
            data_q  <= data_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            drop_q  <= drop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr] <= bus.wr_data;
    end

    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        count_n  = count;
        valid_n  = 1'b0;
        data_n   = '0;
        done_n   = 1'b0;
        drop_n   = 1'b0;
        mem_we   = 1'b0;

        if (bus.clear) begin
            state_n  = IDLE;
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wr_en) begin
                        if (count < DEPTH_W) begin
                            mem_we   = 1'b1;
                            wr_ptr_n = wr_ptr + 1'b1;
                            count_n  = count + 1'b1;
                        end else begin
                            drop_n = 1'b1;
                        end
                    end
                    // Use the post-write count so a same-cycle write joins the burst.
                    if (bus.start) begin
                        if (count_n != '0) begin
                            state_n  = STREAM;
                            rd_ptr_n = '0;
                        end else begin
                            done_n = 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (bus.wr_en) drop_n = 1'b1;
                    if (rd_ptr == count) begin
                        state_n  = IDLE;
                        rd_ptr_n = '0;
                        done_n   = 1'b1;
                    end else if (!bus.stall) begin
                        valid_n  = 1'b1;
                        data_n   = mem[rd_ptr[AW-1:0]];
                        rd_ptr_n = rd_ptr + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        busy_n = (state_n == STREAM);
    end

    assign bus.valid   = valid_q;
    assign bus.data    = data_q;
    assign bus.count   = count;
    assign bus.full    = (count == DEPTH_W);
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wr_drop = drop_q;
endmodule
